bus_rr_arbiter: RTL
===================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter for the shared 16-bit-address / 32-bit-data system bus; replaces the fixed 2-master arbiter.
//  Grants one of NUM_M masters per cycle, with a quantum limit and bus locking.
//  Drives the one-hot grant vector back to the masters.
//  Drives the binary grant index to the bus address/data/wr muxes; parks on DEFAULT_M when idle.
// PARAMETERS
//  NUM_M      4   number of masters, legal 2..8
//  QUANTUM    8   max consecutive owned cycles before preemption under contention, legal 1..255
//  DEFAULT_M  0   park master when no requests, legal 0..NUM_M-1
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  reset      in   1             synchronous, active-high reset
//  m_req      in   NUM_M         per-master bus request, level
//  m_lock     in   NUM_M         per-master lock, honoured only with m_req of the current owner
//  m_grant    out  NUM_M         one-hot grant, registered
//  grant_idx  out  $clog2(NUM_M) binary index of the granted master, registered, drives bus muxes
//  bus_busy   out  1             1 while the owner is actively requesting (state OWN)
//  q_cnt      out  8             cycles used by the current owner, for debug/perf
// BEHAVIOUR
//  Reset values:
//   - m_grant = 1<<DEFAULT_M; grant_idx = DEFAULT_M; bus_busy = 0; q_cnt = 0; state = PARK; rr_ptr = DEFAULT_M.
//   - Reset mid-ownership forces these values on the next edge regardless of req/lock.
//  Grant is always exactly one-hot. Outputs change only on clk edges, never combinationally from inputs.
//  Latency:
//   - req to grant is 1 cycle when the bus is PARKed or the owner releases.
//   - Handover has no gap: the owner drops req in cycle t, and the new grant is visible from edge t+1.
//  Rotating pick:
//   - Search order is rr_ptr+1, rr_ptr+2, ... mod NUM_M, ending with rr_ptr itself.
//   - The first master with m_req=1 wins. rr_ptr = index of the last master granted in OWN.
//  State PARK: no active owner; grant sits on the last parked/default master.
//   - No requests -> stay PARK; grant = DEFAULT_M.
//   - Any request -> OWN with the rotating pick; q_cnt = 0.
//   - Requests from the parked master get no extra priority.
//  State OWN: owner = grant_idx; q_cnt increments each cycle and saturates at 255.
//   - Owner req=0 + other requests -> re-pick (excluding the owner, which is not requesting); q_cnt = 0.
//   - Owner req=0 + no requests -> PARK; grant = DEFAULT_M; q_cnt = 0.
//   - Owner req=1, lock=1 -> hold, never preempted; q_cnt still counts.
//   - Owner req=1, lock=0, q_cnt >= QUANTUM-1, another req present -> preempt to the rotating pick; q_cnt = 0.
//   - Owner req=1, lock=0, no other req -> hold, even past the quantum.
//  QUANTUM=1: under contention, ownership rotates every cycle.
//  Simultaneous events:
//   - Owner release + quantum expiry in the same cycle behave as release.
//   - Lock asserted in the expiry cycle prevents preemption.
//  Lock from a non-owner is ignored.
//  bus_busy = (state == OWN).
//  Address decode and read-data return are outside this block. The slave-select pipeline is unchanged.
// STRUCTURE
//  bus_pkg: ARB_PARK/ARB_OWN state encoding, MAX_M = 8, Q_W = 8, and the bus address/data width constants (16/32).
//  Sub-module rr_pick:
//   - combinational rotating priority encoder;
//   - inputs: req vector, pointer, exclude mask; outputs: found flag, index.
//   - Instantiated once.
//  Top level: 2-state FSM, q_cnt counter, rr_ptr register, grant/index registers.
// TESTING
//  1. Reset with m_req=0000 -> m_grant=0001, grant_idx=0, bus_busy=0; stays so for 10 cycles.
//  2. m_req=0100 from cycle 2 -> m_grant=0100 at edge 3, bus_busy=1.
//     Drop req at cycle 8 -> m_grant=0001, bus_busy=0 at edge 9.
//  3. m_req=1111 held, QUANTUM=8, start from reset:
//     - grant order 1,2,3,0,1, each owner for exactly 8 cycles;
//     - no gap cycles; exactly one grant bit set every cycle.
//  4. Master 1 owns with m_lock=0010, m_req=1010 held for 30 cycles -> master 1 keeps the grant for all 30.
//     Drop lock -> master 3 is granted on the following edge (q_cnt was already past 7).
//  5. Owner 2 drops req in the same cycle its q_cnt=7, while m_req=1001 -> next grant is master 3, q_cnt=0.
//  6. Assert reset while master 3 owns under m_req=1111 ->
//     next edge gives m_grant=0001, q_cnt=0, PARK.
//     One cycle after release, master 1 is granted (rr_ptr=0).

Source files
------------

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin system-bus arbiter.
// State encoding, counter width and the bus geometry the arbiter serves.
package bus_rr_arbiter_pkg;

  localparam int MAX_M      = 8;
  localparam int Q_W        = 8;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 32;

  typedef enum logic {
    ARB_PARK = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Ownership counter sticks at all-ones instead of wrapping.
  function automatic logic [Q_W-1:0] sat_inc(input logic [Q_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
interface bus_rr_arbiter_if
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_M = 4
);

  localparam int IDX_W = $clog2(NUM_M);

  logic [NUM_M-1:0] m_req;
  logic [NUM_M-1:0] m_lock;
  logic [NUM_M-1:0] m_grant;
  logic [IDX_W-1:0] grant_idx;
  logic             bus_busy;
  logic [Q_W-1:0]   q_cnt;

  modport master (
    output m_req, m_lock,
    input  m_grant, grant_idx, bus_busy, q_cnt
  );

  modport slave (
    input  m_req, m_lock,
    output m_grant, grant_idx, bus_busy, q_cnt
  );

endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first requester after ptr_i,
// wrapping round to ptr_i itself, ignoring anything in excl_i.
module bus_rr_arbiter_rr_pick #(
  parameter int NUM_M = 4,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [NUM_M-1:0] excl_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [NUM_M-1:0] cand;

  assign cand = req_i & ~excl_i;

  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    for (int k = 1; k <= NUM_M; k++) begin
      if (!found_o && cand[(int'(ptr_i) + k) % NUM_M]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((int'(ptr_i) + k) % NUM_M);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with per-owner quantum, bus locking and parking
// on DEFAULT_M; all outputs are registered.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_M     = 4,
  parameter int QUANTUM   = 8,
  parameter int DEFAULT_M = 0
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_arbiter_if.slave  arb_if
);

  localparam int               IDX_W   = $clog2(NUM_M);
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_M);
  localparam logic [NUM_M-1:0] DEF_GNT = NUM_M'(1) << DEFAULT_M;
  localparam logic [Q_W-1:0]   Q_LAST  = Q_W'(QUANTUM - 1);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic             busy_q, busy_d;

  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] lock;
  logic [NUM_M-1:0] excl;
  logic             found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             owner_lock;
  logic             others_req;

  assign req  = arb_if.m_req;
  assign lock = arb_if.m_lock;

  // While owning, ptr_q equals the owner, so excluding grant_q skips it.
  assign excl       = (state_q == ARB_OWN) ? grant_q : '0;
  assign owner_req  = req[idx_q];
  assign owner_lock = lock[idx_q];
  assign others_req = |(req & ~grant_q);

  bus_rr_arbiter_rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .excl_i  (excl),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    q_d     = sat_inc(q_q);
    busy_d  = busy_q;
    unique case (state_q)
      ARB_PARK: begin
        if (found) begin
          state_d = ARB_OWN;
          grant_d = NUM_M'(1) << pick_idx;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          q_d     = '0;
          busy_d  = 1'b1;
        end else begin
          grant_d = DEF_GNT;
          idx_d   = DEF_IDX;
          q_d     = '0;
          busy_d  = 1'b0;
        end
      end
      ARB_OWN: begin
        // Release wins over quantum expiry; a held lock blocks preemption.
        if ((!owner_req && found) ||
            (owner_req && !owner_lock && (q_q >= Q_LAST) && others_req)) begin
          grant_d = NUM_M'(1) << pick_idx;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          q_d     = '0;
        end else if (!owner_req) begin
          state_d = ARB_PARK;
          grant_d = DEF_GNT;
          idx_d   = DEF_IDX;
          q_d     = '0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_PARK;
      grant_q <= DEF_GNT;
      idx_q   <= DEF_IDX;
      ptr_q   <= DEF_IDX;
      q_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
    end
  end

  assign arb_if.m_grant   = grant_q;
  assign arb_if.grant_idx = idx_q;
  assign arb_if.bus_busy  = busy_q;
  assign arb_if.q_cnt     = q_q;

endmodule
